// File: rtl/serial_load_ctrl_pkg.sv
// ============================================================
// Package : serial_load_ctrl_pkg
// Brief   : State encodings and default width for the serial-load sequencer.
// Rev     : 1.0
// ============================================================
`default_nettype none

package serial_load_ctrl_pkg;

  localparam int unsigned c_W_DEFAULT = 5;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_CLEAR = 2'd1;
  localparam state_t S_SHIFT = 2'd2;
  localparam state_t S_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/serial_load_ctrl_bit_counter.sv
// ============================================================
// Module : serial_load_ctrl_bit_counter
// Brief  : Saturating bit counter with sync clear and terminal flag at W-1.
// Rev    : 1.0
// ============================================================
`default_nettype none

module serial_load_ctrl_bit_counter #(
  parameter int W     = 5,
  parameter int CNT_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;
  logic             w_tc;

  assign w_tc = (r_count == CNT_W'(W - 1));

  // Saturates at W-1 so a stray enable can never produce an extra shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_tc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = w_tc;

endmodule

`default_nettype wire

// File: rtl/serial_load_ctrl.sv
// ============================================================
// Module : serial_load_ctrl
// Brief  : Captures a word on start/ready, pulses clear, streams it MSB-first.
// Rev    : 1.0
// ============================================================
`default_nettype none

module serial_load_ctrl
  import serial_load_ctrl_pkg::*;
#(
  parameter int W = c_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data_in,
  input  logic         hold,
  input  logic         abort,
  output logic         ready,
  output logic         clr_out,
  output logic         shift_en,
  output logic         ser_bit,
  output logic         done
);

  localparam int CNT_W = $clog2(W);

  state_t           r_state;
  state_t           w_next_state;
  logic [W-1:0]     r_shadow;
  logic [W-1:0]     w_shadow_rev;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_next_idx;
  logic             w_tc;
  logic             w_accept;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             r_clr_out, r_shift_en, r_ser_bit, r_done;
  logic             w_clr_d, w_shift_d, w_bit_d, w_done_d;

  // Reversed view lets the counter index the word MSB-first directly
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rev
      assign w_shadow_rev[gi] = r_shadow[W-1-gi];
    end
  endgenerate

  // Counter holds the index of the bit currently on ser_bit
  serial_load_ctrl_bit_counter #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_cnt_en),
    .i_clr   (w_cnt_clr),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  assign w_next_idx = w_count + CNT_W'(1);
  assign w_accept   = (r_state == S_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next_state = S_CLEAR;
        S_CLEAR: w_next_state = S_SHIFT;
        S_SHIFT: if (!hold && w_tc) w_next_state = S_DONE;
        S_DONE:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; bit 0 leaves on the CLEAR edge
  always_comb begin
    w_clr_d   = 1'b0;
    w_shift_d = 1'b0;
    w_bit_d   = r_ser_bit;
    w_done_d  = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    if (!abort) begin
      case (r_state)
        S_IDLE: begin
          w_clr_d = start;
        end
        S_CLEAR: begin
          w_shift_d = 1'b1;
          w_bit_d   = w_shadow_rev[0];
          w_cnt_clr = 1'b1;
        end
        S_SHIFT: begin
          if (!hold) begin
            if (w_tc) begin
              w_done_d = 1'b1;
            end else begin
              w_shift_d = 1'b1;
              w_bit_d   = w_shadow_rev[w_next_idx];
              w_cnt_en  = 1'b1;
            end
          end
        end
        default: begin
          w_done_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow   <= '0;
      r_clr_out  <= 1'b0;
      r_shift_en <= 1'b0;
      r_ser_bit  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shadow <= data_in;
      end
      r_clr_out  <= w_clr_d;
      r_shift_en <= w_shift_d;
      r_ser_bit  <= w_bit_d;
      r_done     <= w_done_d;
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign clr_out  = r_clr_out;
  assign shift_en = r_shift_en;
  assign ser_bit  = r_ser_bit;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_load_ctrl.sv
// ============================================================
// Module : tb_serial_load_ctrl
// Brief  : Directed bench for serial_load_ctrl with a downstream shift-register model.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_serial_load_ctrl;

  localparam int W = 5;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic         hold;
  logic         abort;
  logic         ready;
  logic         clr_out;
  logic         shift_en;
  logic         ser_bit;
  logic         done;
  logic [W-1:0] q = '0;

  int n_checks = 0;
  int n_fail   = 0;

  serial_load_ctrl #(.W(W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .hold     (hold),
    .abort    (abort),
    .ready    (ready),
    .clr_out  (clr_out),
    .shift_en (shift_en),
    .ser_bit  (ser_bit),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream serial-load register, not reset by the controller
  always @(posedge clk) begin
    if (clr_out)       q <= '0;
    else if (shift_en) q <= {q[W-2:0], ser_bit};
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transfer; cycle c counts from the accepting edge (c=1 is the CLEAR cycle)
  task automatic xfer(input logic [W-1:0] word, input int h0, input int hl, input int ab,
                      input bit scramble, output int n_sh, output int t_done,
                      output int n_done, output int t_clr, output logic [W-1:0] bits);
    bit fin;
    data_in = word;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    n_sh   = 0;
    t_done = 0;
    n_done = 0;
    t_clr  = 0;
    bits   = '0;
    fin    = 1'b0;
    for (int c = 1; c < 40 && !fin; c++) begin
      if (c >= 2) chk_eq("q_seq", 32'(q), 32'(word) >> (W - n_sh));
      if (clr_out) t_clr = c;
      if (shift_en) begin
        bits = {bits[W-2:0], ser_bit};
        n_sh++;
      end
      if (done) begin
        t_done = c;
        n_done++;
      end
      if (ready) begin
        fin = 1'b1;
      end else begin
        hold  = (c >= h0) && (c < h0 + hl);
        abort = (c == ab);
        if (scramble) data_in = ~data_in ^ W'(c);
        tick();
        abort = 1'b0;
      end
    end
    hold = 1'b0;
    chk_eq("xfer_end_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           n_sh, t_done, n_done, t_clr;
    logic [W-1:0] bits, bits_b, q_save;
    int           t_clr2, t_sh_b, t_done_a, t_done_b, n_extra;

    rst = 1'b0; start = 1'b0; data_in = '0; hold = 1'b0; abort = 1'b0;
    tick(); tick();
    chk_eq("rst_ready",    32'(ready),    32'd1);
    chk_eq("rst_clr_out",  32'(clr_out),  32'd0);
    chk_eq("rst_shift_en", 32'(shift_en), 32'd0);
    chk_eq("rst_ser_bit",  32'(ser_bit),  32'd0);
    chk_eq("rst_done",     32'(done),     32'd0);
    rst = 1'b1;
    tick();

    // Nominal transfer
    xfer(5'b10101, 0, 0, 0, 1'b0, n_sh, t_done, n_done, t_clr, bits);
    chk_eq("nom_clr_cycle", 32'(t_clr),  32'd1);
    chk_eq("nom_shifts",    32'(n_sh),   32'd5);
    chk_eq("nom_bits",      32'(bits),   32'b10101);
    chk_eq("nom_done_cyc",  32'(t_done), 32'd7);
    chk_eq("nom_done_once", 32'(n_done), 32'd1);
    chk_eq("nom_q",         32'(q),      32'b10101);

    // Hold for three cycles after the second bit
    xfer(5'b11001, 3, 3, 0, 1'b0, n_sh, t_done, n_done, t_clr, bits);
    chk_eq("hold_shifts",   32'(n_sh),   32'd5);
    chk_eq("hold_bits",     32'(bits),   32'b11001);
    chk_eq("hold_done_cyc", 32'(t_done), 32'd10);
    chk_eq("hold_q",        32'(q),      32'b11001);

    // Abort after the second bit
    xfer(5'b11111, 0, 0, 3, 1'b0, n_sh, t_done, n_done, t_clr, bits);
    chk_eq("abort_shifts",  32'(n_sh),     32'd2);
    chk_eq("abort_no_done", 32'(n_done),   32'd0);
    chk_eq("abort_q",       32'(q),        32'b00011);
    chk_eq("abort_shen",    32'(shift_en), 32'd0);

    // Data changes every cycle after acceptance
    xfer(5'b01101, 0, 0, 0, 1'b1, n_sh, t_done, n_done, t_clr, bits);
    chk_eq("stab_bits", 32'(bits), 32'b01101);
    chk_eq("stab_q",    32'(q),    32'b01101);

    // Start held high: busy start ignored, second word accepted after DONE
    data_in = 5'b10110;
    start   = 1'b1;
    tick();
    data_in  = 5'b00111;
    bits     = '0;
    bits_b   = '0;
    t_clr2   = 0;
    t_sh_b   = 0;
    t_done_a = 0;
    t_done_b = 0;
    for (int c = 1; c < 20; c++) begin
      if (clr_out && c > 1) t_clr2 = c;
      if (shift_en) begin
        if (c <= 6) bits = {bits[W-2:0], ser_bit};
        else begin
          bits_b = {bits_b[W-2:0], ser_bit};
          if (t_sh_b == 0) t_sh_b = c;
        end
      end
      if (done) begin
        if (t_done_a == 0) t_done_a = c;
        else               t_done_b = c;
      end
      start = (c <= 8);
      tick();
    end
    start = 1'b0;
    chk_eq("hs_bits_a",   32'(bits),     32'b10110);
    chk_eq("hs_done_a",   32'(t_done_a), 32'd7);
    chk_eq("hs_clr_b",    32'(t_clr2),   32'd9);
    chk_eq("hs_first_sh", 32'(t_sh_b),   32'd10);
    chk_eq("hs_bits_b",   32'(bits_b),   32'b00111);
    chk_eq("hs_done_b",   32'(t_done_b), 32'd15);
    chk_eq("hs_q",        32'(q),        32'b00111);

    // Asynchronous reset in the middle of SHIFT
    data_in = 5'b10011;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk_eq("mid_shift_en", 32'(shift_en), 32'd1);
    q_save = q;
    #2;
    rst = 1'b0;
    #1;
    chk_eq("arst_ready",    32'(ready),    32'd1);
    chk_eq("arst_shift_en", 32'(shift_en), 32'd0);
    chk_eq("arst_clr_out",  32'(clr_out),  32'd0);
    chk_eq("arst_ser_bit",  32'(ser_bit),  32'd0);
    chk_eq("arst_done",     32'(done),     32'd0);
    tick();
    chk_eq("arst_q_kept", 32'(q), 32'(q_save));
    rst = 1'b1;
    n_extra = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (shift_en || done || clr_out) n_extra++;
    end
    chk_eq("arst_quiet", 32'(n_extra), 32'd0);
    chk_eq("arst_idle",  32'(ready),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
